pc_gen: RTL and testbench

- Parametrised fetch-address generator replacing the plain PC register at the head of the MIPS core fetch stage.
- Holds the current PC and drives it to instruction memory under a valid/ready handshake; advances sequentially by INSTR_BYTES.
- Adds execute-stage redirect, halt/resume control and an internal return-address stack (RAS) for call/return prediction from decode.

---
 rtl/mips_core_pkg.sv | 14 +
 rtl/return_addr_stack.sv | 54 +++++
 rtl/pc_gen.sv | 123 ++++++++++++
 tb/tb_pc_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared MIPS core types and fetch-stage defaults.
package mips_core_pkg;

  // Fetch-address generator control states
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int          DEF_INSTR_BYTES  = 4;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a push past full overwrites the oldest entry.
module return_addr_stack #(
  parameter int RAS_DEPTH = 4,
  parameter int XLEN      = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [XLEN-1:0] i_push_addr,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty,
  output logic            o_full,
  output logic            o_underflow
);
  import mips_core_pkg::*;

  localparam int PW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   tp_q;
  logic [PW-1:0]   tp_inc;
  logic [PW-1:0]   tp_dec;
  logic [PW:0]     cnt_q;

  assign tp_inc      = tp_q + PW'(1);
  assign tp_dec      = tp_q - PW'(1);
  assign o_empty     = (cnt_q == '0);
  assign o_full      = (cnt_q == (PW+1)'(RAS_DEPTH));
  assign o_top       = mem_q[tp_q];
  // A pop against an empty stack is the only underflow case; a paired
  // push still lands.
  assign o_underflow = i_pop & o_empty;

  // Stack update: push+pop swaps the top in place, otherwise push or pop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
    end else if (i_push && i_pop && !o_empty) begin
      mem_q[tp_q] <= i_push_addr;
    end else if (i_push) begin
      // When full, tp+1 is the oldest slot, so this is the circular overwrite
      mem_q[tp_inc] <= i_push_addr;
      tp_q          <= tp_inc;
      if (!o_full) cnt_q <= cnt_q + (PW+1)'(1);
    end else if (i_pop && !o_empty) begin
      tp_q  <= tp_dec;
      cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: PC register with handshake, redirect, halt and RAS.
module pc_gen
  import mips_core_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int              INSTR_BYTES  = DEF_INSTR_BYTES,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_fetch_ready,
  output logic            o_fetch_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_seq,
  input  logic            i_stall,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_target,
  input  logic            i_halt,
  input  logic            i_resume,
  input  logic            i_push_valid,
  input  logic [XLEN-1:0] i_push_addr,
  input  logic            i_pop_valid,
  output logic            o_ras_empty,
  output logic            o_ras_full,
  output logic            o_misaligned,
  output logic            o_ras_underflow
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);

  pc_state_e       state_q;
  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            mis_q;
  logic            unf_q;

  logic            fire;
  logic            redir;
  logic            push_hon;
  logic            pop_hon;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_unf;

  assign o_fetch_valid   = valid_q;
  assign o_pc            = pc_q;
  assign o_pc_seq        = pc_q + XLEN'(INSTR_BYTES);
  assign o_misaligned    = mis_q;
  assign o_ras_underflow = unf_q;
  assign o_ras_empty     = ras_empty;

  assign fire     = valid_q & i_fetch_ready & ~i_stall;
  assign redir    = i_redirect_valid & (state_q != BOOT);
  assign push_hon = i_push_valid & (state_q != BOOT);
  // Pops are only consumed alongside an accepted fetch; otherwise decode holds them
  assign pop_hon  = i_pop_valid & fire & ~redir;

  return_addr_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .XLEN      (XLEN)
  ) u_ras (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (push_hon),
    .i_pop       (pop_hon),
    .i_push_addr (i_push_addr),
    .o_top       (ras_top),
    .o_empty     (ras_empty),
    .o_full      (o_ras_full),
    .o_underflow (ras_unf)
  );

  // Next-PC select: redirect > return prediction > sequential > hold
  always_comb begin
    pc_d = pc_q;
    if (redir)                     pc_d = i_redirect_target & ~LOW_MASK;
    else if (pop_hon && !ras_empty) pc_d = ras_top;
    else if (fire)                 pc_d = o_pc_seq;
  end

  // Control FSM with registered fetch-valid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= BOOT;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        RUN: if (i_halt) begin
          state_q <= HALT;
          valid_q <= 1'b0;
        end
        HALT: if (i_resume) begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        default: begin
          state_q <= BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // PC register and one-cycle status pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q  <= RESET_VECTOR;
      mis_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= redir & |(i_redirect_target & LOW_MASK);
      unf_q <= pop_hon & ras_unf;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed table-driven bench for pc_gen.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy, stl, rv, hlt, res, pu, po;
  logic [31:0] rt, pa;
  logic        vld, emp, ful, mis, unf;
  logic [31:0] pc, pcs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_fetch_ready     (rdy),
    .o_fetch_valid     (vld),
    .o_pc              (pc),
    .o_pc_seq          (pcs),
    .i_stall           (stl),
    .i_redirect_valid  (rv),
    .i_redirect_target (rt),
    .i_halt            (hlt),
    .i_resume          (res),
    .i_push_valid      (pu),
    .i_push_addr       (pa),
    .i_pop_valid       (po),
    .o_ras_empty       (emp),
    .o_ras_full        (ful),
    .o_misaligned      (mis),
    .o_ras_underflow   (unf)
  );

  typedef struct {
    logic        rdy, stl, rv;
    logic [31:0] rt;
    logic        hlt, res, pu;
    logic [31:0] pa;
    logic        po;
    logic [31:0] e_pc;
    logic        e_vld, e_mis, e_unf, e_emp, e_ful;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic r, s, rvi, input logic [31:0] rti,
                   input logic h, rs, p, input logic [31:0] pai, input logic pp,
                   input logic [31:0] epc, input logic ev, em, eu, ee, ef);
    vec_t t;
    t.rdy = r; t.stl = s; t.rv = rvi; t.rt = rti; t.hlt = h; t.res = rs;
    t.pu = p; t.pa = pai; t.po = pp; t.e_pc = epc; t.e_vld = ev;
    t.e_mis = em; t.e_unf = eu; t.e_emp = ee; t.e_ful = ef;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic idle();
    rdy = 0; stl = 0; rv = 0; rt = 0; hlt = 0; res = 0; pu = 0; pa = 0; po = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #3;
    chk("rst_pc", -1, pc, 32'h0);
    chk("rst_vld", -1, {31'b0, vld}, 32'h0);
    chk("rst_empty", -1, {31'b0, emp}, 32'h1);
    chk("rst_full", -1, {31'b0, ful}, 32'h0);
    chk("rst_pulses", -1, {30'b0, mis, unf}, 32'h0);
    step(); step();
    rst_n = 1'b1;

    //  rdy stl rv target        hlt res pu addr  po   pc            vld mis unf emp ful
    v(1,0,0,32'h0,        0,0,0,32'h0,  0, 32'h0,        1,0,0,1,0); // BOOT->RUN
    v(1,0,0,32'h0,        0,0,0,32'h0,  0, 32'h4,        1,0,0,1,0);
    v(1,0,0,32'h0,        0,0,0,32'h0,  0, 32'h8,        1,0,0,1,0);
    v(1,1,0,32'h0,        0,0,0,32'h0,  0, 32'h8,        1,0,0,1,0); // stall
    v(0,0,0,32'h0,        0,0,0,32'h0,  0, 32'h8,        1,0,0,1,0); // not ready
    v(1,0,0,32'h0,        0,0,0,32'h0,  0, 32'hC,        1,0,0,1,0);
    v(0,1,1,32'h100,      0,0,0,32'h0,  0, 32'h100,      1,0,0,1,0); // redirect under stall
    v(1,0,1,32'h102,      0,0,0,32'h0,  0, 32'h100,      1,1,0,1,0); // misaligned
    v(1,0,0,32'h0,        0,0,0,32'h0,  0, 32'h104,      1,0,0,1,0);
    v(0,0,0,32'h0,        0,0,1,32'h40, 0, 32'h104,      1,0,0,0,0);
    v(0,0,0,32'h0,        0,0,1,32'h80, 0, 32'h104,      1,0,0,0,0);
    v(1,0,0,32'h0,        0,0,0,32'h0,  1, 32'h80,       1,0,0,0,0);
    v(1,0,0,32'h0,        0,0,0,32'h0,  1, 32'h40,       1,0,0,1,0);
    v(1,0,0,32'h0,        0,0,0,32'h0,  1, 32'h44,       1,0,1,1,0); // underflow
    v(0,0,0,32'h0,        0,0,0,32'h0,  0, 32'h44,       1,0,0,1,0);
    v(0,0,0,32'h0,        0,0,1,32'h10, 0, 32'h44,       1,0,0,0,0);
    v(0,0,0,32'h0,        0,0,1,32'h20, 0, 32'h44,       1,0,0,0,0);
    v(0,0,0,32'h0,        0,0,1,32'h30, 0, 32'h44,       1,0,0,0,0);
    v(0,0,0,32'h0,        0,0,1,32'h40, 0, 32'h44,       1,0,0,0,1);
    v(0,0,0,32'h0,        0,0,1,32'h50, 0, 32'h44,       1,0,0,0,1); // overwrite oldest
    v(1,0,0,32'h0,        0,0,0,32'h0,  1, 32'h50,       1,0,0,0,0);
    v(1,0,0,32'h0,        0,0,0,32'h0,  1, 32'h40,       1,0,0,0,0);
    v(1,0,0,32'h0,        0,0,0,32'h0,  1, 32'h30,       1,0,0,0,0);
    v(1,0,0,32'h0,        0,0,0,32'h0,  1, 32'h20,       1,0,0,1,0);
    v(1,0,0,32'h0,        0,0,1,32'h300,1, 32'h24,       1,0,1,0,0); // push+pop on empty
    v(1,0,0,32'h0,        0,0,1,32'h400,1, 32'h300,      1,0,0,0,0); // push+pop swap
    v(1,0,0,32'h0,        0,0,0,32'h0,  1, 32'h400,      1,0,0,1,0);
    v(0,0,0,32'h0,        0,0,1,32'h500,0, 32'h400,      1,0,0,0,0);
    v(1,0,1,32'h600,      0,0,0,32'h0,  1, 32'h600,      1,0,0,0,0); // pop lost to redirect
    v(0,0,0,32'h0,        0,0,0,32'h0,  1, 32'h600,      1,0,0,0,0); // pop without fire
    v(1,0,0,32'h0,        0,0,0,32'h0,  1, 32'h500,      1,0,0,1,0);
    v(0,0,0,32'h0,        1,0,0,32'h0,  0, 32'h500,      0,0,0,1,0); // halt
    v(1,0,0,32'h0,        0,0,0,32'h0,  0, 32'h500,      0,0,0,1,0);
    v(1,0,1,32'h200,      0,0,0,32'h0,  0, 32'h200,      0,0,0,1,0); // redirect in HALT
    v(1,0,0,32'h0,        1,1,0,32'h0,  0, 32'h200,      1,0,0,1,0); // resume wins in HALT
    v(1,0,0,32'h0,        0,0,0,32'h0,  0, 32'h204,      1,0,0,1,0);
    v(1,0,0,32'h0,        1,1,0,32'h0,  0, 32'h208,      0,0,0,1,0); // halt wins in RUN
    v(1,0,0,32'h0,        0,1,0,32'h0,  0, 32'h208,      1,0,0,1,0);
    v(0,0,1,32'hFFFF_FFFE,1,0,0,32'h0,  0, 32'hFFFF_FFFC, 0,1,0,1,0); // halt+redirect
    v(0,0,0,32'h0,        0,1,0,32'h0,  0, 32'hFFFF_FFFC, 1,0,0,1,0);
    v(1,0,0,32'h0,        0,0,0,32'h0,  0, 32'h0,        1,0,0,1,0); // wrap

    foreach (tbl[i]) begin
      rdy = tbl[i].rdy; stl = tbl[i].stl; rv = tbl[i].rv; rt = tbl[i].rt;
      hlt = tbl[i].hlt; res = tbl[i].res; pu = tbl[i].pu; pa = tbl[i].pa;
      po = tbl[i].po;
      step();
      chk("pc", i, pc, tbl[i].e_pc);
      chk("pc_seq", i, pcs, tbl[i].e_pc + 32'd4);
      chk("valid", i, {31'b0, vld}, {31'b0, tbl[i].e_vld});
      chk("misaligned", i, {31'b0, mis}, {31'b0, tbl[i].e_mis});
      chk("underflow", i, {31'b0, unf}, {31'b0, tbl[i].e_unf});
      chk("empty", i, {31'b0, emp}, {31'b0, tbl[i].e_emp});
      chk("full", i, {31'b0, ful}, {31'b0, tbl[i].e_ful});
    end

    // Mid-operation reset discards RAS, then a BOOT-cycle push is ignored
    idle();
    pu = 1; pa = 32'h70; step();
    pa = 32'h74; rdy = 1; step();
    idle();
    chk("pre_rst_empty", 100, {31'b0, emp}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", 101, pc, 32'h0);
    chk("mid_rst_vld", 101, {31'b0, vld}, 32'h0);
    chk("mid_rst_empty", 101, {31'b0, emp}, 32'h1);
    step();
    rst_n = 1'b1;
    pu = 1; pa = 32'h700; rdy = 1;
    step();
    chk("boot_push_ignored", 102, {31'b0, emp}, 32'h1);
    chk("boot_vld", 102, {31'b0, vld}, 32'h1);
    chk("boot_pc", 102, pc, 32'h0);
    pu = 0;
    step();
    chk("post_boot_pc", 103, pc, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop so the bench always terminates
  initial begin
    #100000;
    $display("FAIL timeout step=-1 got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
